// File: rtl/s526a_bist_pkg.sv
// Shared types and constants for the s526a BIST response path.
package s526a_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // Bit positions of the core outputs within RESP.
   localparam int RESP_W   = 6;
   localparam int IDX_G147 = 0;
   localparam int IDX_G148 = 1;
   localparam int IDX_G198 = 2;
   localparam int IDX_G199 = 3;
   localparam int IDX_G213 = 4;
   localparam int IDX_G214 = 5;

   localparam logic [15:0] DEF_POLY = 16'h1021;
   localparam logic [15:0] DEF_SEED = 16'hFFFF;

endpackage

// File: rtl/misr_step.sv
// One MISR update: shift left, fold in POLY when the MSB leaves, xor in the response.
module misr_step
   import s526a_bist_pkg::*;
#(
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
   input  logic [SIG_W-1:0]  s,
   input  logic [RESP_W-1:0] r,
   output logic [SIG_W-1:0]  nxt
);

   always_comb begin
      nxt = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ SIG_W'(r);
   end

endmodule

// File: rtl/s526a_resp_misr.sv
// Response compactor: folds RESP into a MISR over a fixed window, then compares
// the final signature against EXP_SIG.
module s526a_resp_misr
   import s526a_bist_pkg::*;
#(
   parameter int               SIG_W   = 16,
   parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
   parameter logic [SIG_W-1:0] SEED    = SIG_W'(DEF_SEED),
   parameter int               WIN_LEN = 256,
   parameter int               CNT_W   = 16
) (
   input  logic                CK,
   input  logic                RN,
   input  logic                START,
   input  logic [RESP_W-1:0]   RESP,
   input  logic [SIG_W-1:0]    EXP_SIG,
   output logic                BUSY,
   output logic                DONE,
   output logic                PASS,
   output logic [SIG_W-1:0]    SIG,
   output logic [CNT_W-1:0]    CNT
);

   state_t           state_q, state_d;
   logic [SIG_W-1:0] sig_nxt;
   logic             last;

   misr_step #(
      .SIG_W (SIG_W),
      .POLY  (POLY)
   ) u_step (
      .s   (SIG),
      .r   (RESP),
      .nxt (sig_nxt)
   );

   assign last = (CNT == CNT_W'(WIN_LEN - 1));

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (START) state_d = ST_RUN;
         ST_RUN:  if (last)  state_d = ST_DONE;
         ST_DONE: if (START) state_d = ST_RUN;
         default:            state_d = ST_IDLE;
      endcase
   end

   // Status flags are registered from the next state so they change on the
   // same edge as the state itself.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         BUSY <= 1'b0;
         DONE <= 1'b0;
      end else begin
         BUSY <= (state_d == ST_RUN);
         DONE <= (state_d == ST_DONE);
      end
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         SIG  <= SEED;
         CNT  <= '0;
         PASS <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (START) begin
                  SIG <= SEED;
                  CNT <= '0;
               end
            end
            ST_RUN: begin
               SIG <= sig_nxt;
               CNT <= CNT + CNT_W'(1);
               if (last) PASS <= (sig_nxt == EXP_SIG);
            end
            ST_DONE: begin
               if (START) begin
                  SIG  <= SEED;
                  CNT  <= '0;
                  PASS <= 1'b0;
               end
            end
            default: begin
               SIG  <= SEED;
               CNT  <= '0;
               PASS <= 1'b0;
            end
         endcase
      end
   end

endmodule
